// File: rtl/spi_slave_fabric.sv
// Mode-0, MSB-first SPI slave oversampled in the fabric clock domain, with a
// one-word TX holding register and valid/ready word interfaces to firmware.
module spi_slave_fabric #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TX_DEFAULT = {DATA_WIDTH{1'b0}}
) (
  input  logic                  FAB_CCC_GL0,
  input  logic                  FAB_RESET_N,
  input  logic                  s_sck,
  input  logic                  s_ss,
  input  logic                  s_mosi,
  output logic                  s_miso,
  output logic                  s_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t state_r, state_next_s;

  logic sck_meta_r, sck_sync_r, sck_d_r, sck_rise_r, sck_fall_r;
  logic ss_meta_r, ss_sync_r, ss_d_r, ss_rise_r, ss_fall_r;
  logic mosi_meta_r, mosi_sync_r;

  logic                  hold_full_r;
  logic [DATA_WIDTH-1:0] hold_data_r;
  logic [DATA_WIDTH-1:0] tx_shift_r;
  logic [DATA_WIDTH-1:0] rx_shift_r;
  logic [DATA_WIDTH-1:0] rx_data_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  word_done_r;
  logic                  underrun_pend_r;
  logic                  miso_r, miso_oe_r, rx_valid_r, tx_underrun_r, frame_abort_r, busy_r;

  logic                  load_s, shift_s, sample_s, capture_s, abort_s, end_s;
  logic                  tx_accept_s;
  logic [DATA_WIDTH-1:0] load_word_s;
  logic [DATA_WIDTH-1:0] rx_word_s;

  assign tx_accept_s = tx_valid & ~hold_full_r;
  assign load_word_s = hold_full_r ? hold_data_r : TX_DEFAULT;
  assign rx_word_s   = {rx_shift_r[DATA_WIDTH-2:0], mosi_sync_r};

  // Two-flop synchronizers plus a delay stage and registered edge pulses
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      sck_meta_r  <= 1'b1;
      sck_sync_r  <= 1'b1;
      sck_d_r     <= 1'b1;
      sck_rise_r  <= 1'b0;
      sck_fall_r  <= 1'b0;
      ss_meta_r   <= 1'b1;
      ss_sync_r   <= 1'b1;
      ss_d_r      <= 1'b1;
      ss_rise_r   <= 1'b0;
      ss_fall_r   <= 1'b0;
      mosi_meta_r <= 1'b1;
      mosi_sync_r <= 1'b1;
    end else begin
      sck_meta_r  <= s_sck;
      sck_sync_r  <= sck_meta_r;
      sck_d_r     <= sck_sync_r;
      sck_rise_r  <= sck_sync_r & ~sck_d_r;
      sck_fall_r  <= ~sck_sync_r & sck_d_r;
      ss_meta_r   <= s_ss;
      ss_sync_r   <= ss_meta_r;
      ss_d_r      <= ss_sync_r;
      ss_rise_r   <= ss_sync_r & ~ss_d_r;
      ss_fall_r   <= ~ss_sync_r & ss_d_r;
      mosi_meta_r <= s_mosi;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  // FSM state register
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle control strobes; ss edges win over sck edges
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    sample_s     = 1'b0;
    capture_s    = 1'b0;
    abort_s      = 1'b0;
    end_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ss_fall_r) begin
          state_next_s = ST_ACTIVE;
          load_s       = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise_r) begin
          state_next_s = ST_IDLE;
          end_s        = 1'b1;
          abort_s      = (bit_cnt_r != {CNT_W{1'b0}});
        end else if (sck_rise_r) begin
          sample_s  = 1'b1;
          capture_s = (bit_cnt_r == LAST_BIT);
        end else if (sck_fall_r) begin
          if (word_done_r) begin
            load_s = 1'b1;
          end else begin
            shift_s = 1'b1;
          end
        end else begin
          state_next_s = ST_ACTIVE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // One-word TX holding register; a load and an accept are never concurrent while full
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      hold_full_r <= 1'b0;
      hold_data_r <= {DATA_WIDTH{1'b0}};
    end else if (tx_accept_s) begin
      hold_full_r <= 1'b1;
      hold_data_r <= tx_data;
    end else if (load_s) begin
      hold_full_r <= 1'b0;
    end
  end

  // Shift registers, bit counter and word boundary bookkeeping
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      tx_shift_r  <= {DATA_WIDTH{1'b0}};
      rx_shift_r  <= {DATA_WIDTH{1'b0}};
      rx_data_r   <= {DATA_WIDTH{1'b0}};
      bit_cnt_r   <= {CNT_W{1'b0}};
      word_done_r <= 1'b0;
    end else begin
      if (load_s) begin
        tx_shift_r <= load_word_s;
      end else if (shift_s) begin
        tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
      end
      if (sample_s) begin
        rx_shift_r <= rx_word_s;
      end
      if (capture_s) begin
        rx_data_r <= rx_word_s;
      end
      if (end_s || capture_s) begin
        bit_cnt_r <= {CNT_W{1'b0}};
      end else if (sample_s) begin
        bit_cnt_r <= bit_cnt_r + CNT_ONE;
      end
      if (end_s) begin
        word_done_r <= 1'b0;
      end else if (capture_s) begin
        word_done_r <= 1'b1;
      end else if (load_s) begin
        word_done_r <= 1'b0;
      end
    end
  end

  // A default word loaded at a boundary is only reported once the master clocks it;
  // the trailing reload after the last word of a frame is never reported.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      underrun_pend_r <= 1'b0;
    end else if (end_s) begin
      underrun_pend_r <= 1'b0;
    end else if (load_s && (state_r == ST_ACTIVE)) begin
      underrun_pend_r <= ~hold_full_r;
    end else if (sample_s) begin
      underrun_pend_r <= 1'b0;
    end
  end

  // Registered pad and status outputs
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      miso_r        <= 1'b1;
      miso_oe_r     <= 1'b0;
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      frame_abort_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      if (end_s) begin
        miso_r <= 1'b1;
      end else if (load_s) begin
        miso_r <= load_word_s[DATA_WIDTH-1];
      end else if (shift_s) begin
        miso_r <= tx_shift_r[DATA_WIDTH-2];
      end
      miso_oe_r     <= (state_next_s == ST_ACTIVE);
      busy_r        <= (state_next_s == ST_ACTIVE);
      rx_valid_r    <= capture_s;
      frame_abort_r <= abort_s;
      tx_underrun_r <= (load_s & ~hold_full_r & (state_r == ST_IDLE)) |
                       (sample_s & underrun_pend_r);
    end
  end

  assign s_miso      = miso_r;
  assign s_miso_oe   = miso_oe_r;
  assign tx_ready    = ~hold_full_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = tx_underrun_r;
  assign frame_abort = frame_abort_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_spi_slave_fabric.sv
// Scoreboard bench for spi_slave_fabric: an 8-bit and a 16-bit instance share
// sck/mosi; each has its own slave select and TX/RX interfaces.
module tb_spi_slave_fabric;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, s_sck, s_mosi, ss8, ss16;

  logic       miso8, oe8, tx_valid8, tx_ready8, rx_valid8, under8, abort8, busy8;
  logic [7:0] tx_data8, rx_data8;
  logic        miso16, oe16, tx_valid16, tx_ready16, rx_valid16, under16, abort16, busy16;
  logic [15:0] tx_data16, rx_data16;

  int checks = 0;
  int errors = 0;
  int under8_cnt = 0;
  int abort8_cnt = 0;
  logic [7:0]  exp8_q[$];
  logic [15:0] exp16_q[$];
  logic [31:0] mosi_words[4];
  logic [31:0] miso_words[4];

  spi_slave_fabric #(.DATA_WIDTH(8), .TX_DEFAULT(8'h00)) dut8 (
    .FAB_CCC_GL0(clk), .FAB_RESET_N(rst_n), .s_sck(s_sck), .s_ss(ss8), .s_mosi(s_mosi),
    .s_miso(miso8), .s_miso_oe(oe8), .tx_data(tx_data8), .tx_valid(tx_valid8),
    .tx_ready(tx_ready8), .rx_data(rx_data8), .rx_valid(rx_valid8),
    .tx_underrun(under8), .frame_abort(abort8), .busy(busy8)
  );

  spi_slave_fabric #(.DATA_WIDTH(16), .TX_DEFAULT(16'h0000)) dut16 (
    .FAB_CCC_GL0(clk), .FAB_RESET_N(rst_n), .s_sck(s_sck), .s_ss(ss16), .s_mosi(s_mosi),
    .s_miso(miso16), .s_miso_oe(oe16), .tx_data(tx_data16), .tx_valid(tx_valid16),
    .tx_ready(tx_ready16), .rx_data(rx_data16), .rx_valid(rx_valid16),
    .tx_underrun(under16), .frame_abort(abort16), .busy(busy16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input bit is16, input logic [15:0] d);
    int t = 0;
    while (!(is16 ? tx_ready16 : tx_ready8) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", {31'd0, (t < 2000)}, 32'd1);
    if (is16) begin
      tx_data16 = d;
      tx_valid16 = 1'b1;
    end else begin
      tx_data8 = d[7:0];
      tx_valid8 = 1'b1;
    end
    @(negedge clk);
    tx_valid8 = 1'b0;
    tx_valid16 = 1'b0;
  endtask

  // Mode-0 master: MOSI set in the low phase, MISO sampled just before the rise
  task automatic frame(input int w, input int nbits, input bit sel16, input bit jit, input bit end_ss);
    int lo, hi, wi, bi;
    for (int k = 0; k < 4; k++) miso_words[k] = 32'd0;
    if (sel16) ss16 = 1'b0; else ss8 = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      lo = jit ? int'($urandom_range(4, 7)) : 4;
      hi = jit ? int'($urandom_range(4, 7)) : 4;
      wi = b / w;
      bi = w - 1 - (b % w);
      s_mosi = mosi_words[wi][bi];
      repeat (lo) @(negedge clk);
      miso_words[wi][bi] = sel16 ? miso16 : miso8;
      s_sck = 1'b1;
      repeat (hi) @(negedge clk);
      s_sck = 1'b0;
    end
    repeat (8) @(negedge clk);
    if (end_ss) begin
      ss8 = 1'b1;
      ss16 = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, {31'd0, miso8}, 32'd1);
    check({tag, "_oe"}, {31'd0, oe8}, 32'd0);
    check({tag, "_rx_data"}, {24'd0, rx_data8}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid8}, 32'd0);
    check({tag, "_tx_ready"}, {31'd0, tx_ready8}, 32'd1);
    check({tag, "_underrun"}, {31'd0, under8}, 32'd0);
    check({tag, "_abort"}, {31'd0, abort8}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    int u0, a0;
    rst_n = 1'b0; s_sck = 1'b0; s_mosi = 1'b0; ss8 = 1'b1; ss16 = 1'b1;
    tx_valid8 = 1'b0; tx_data8 = 8'h00; tx_valid16 = 1'b0; tx_data16 = 16'h0000;

    // Monitor: pops the scoreboard whenever either DUT presents rx_valid
    fork
      forever begin
        @(negedge clk);
        if (rst_n && rx_valid8) begin
          if (exp8_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx8_unexpected: got 0x%0h, expected no word", rx_data8);
          end else begin
            check("rx8_data", {24'd0, rx_data8}, {24'd0, exp8_q.pop_front()});
          end
        end
        if (rst_n && rx_valid16) begin
          if (exp16_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx16_unexpected: got 0x%0h, expected no word", rx_data16);
          end else begin
            check("rx16_data", {16'd0, rx_data16}, {16'd0, exp16_q.pop_front()});
          end
        end
        if (rst_n && under8) under8_cnt++;
        if (rst_n && abort8) abort8_cnt++;
      end
    join_none

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single word
    push_tx(1'b0, 16'h00A5);
    u0 = under8_cnt;
    exp8_q.push_back(8'h3C);
    mosi_words[0] = 32'h3C;
    frame(8, 8, 1'b0, 1'b0, 1'b1);
    check("single_miso", miso_words[0], 32'hA5);
    check("single_underrun", under8_cnt - u0, 32'd0);
    check("single_tx_ready", {31'd0, tx_ready8}, 32'd1);
    check("single_drain", exp8_q.size(), 32'd0);

    // Back-to-back words, second TX word queued mid-frame
    push_tx(1'b0, 16'h0011);
    u0 = under8_cnt;
    exp8_q.push_back(8'hF0); exp8_q.push_back(8'h0F);
    mosi_words[0] = 32'hF0; mosi_words[1] = 32'h0F;
    fork
      frame(8, 16, 1'b0, 1'b0, 1'b1);
      push_tx(1'b0, 16'h0022);
    join
    check("b2b_miso0", miso_words[0], 32'h11);
    check("b2b_miso1", miso_words[1], 32'h22);
    check("b2b_underrun", under8_cnt - u0, 32'd0);
    check("b2b_drain", exp8_q.size(), 32'd0);

    // Underrun: ss fall and the word-1 boundary both fall back to TX_DEFAULT
    u0 = under8_cnt;
    exp8_q.push_back(8'h55); exp8_q.push_back(8'hAA);
    mosi_words[0] = 32'h55; mosi_words[1] = 32'hAA;
    frame(8, 16, 1'b0, 1'b0, 1'b1);
    check("under_miso0", miso_words[0], 32'h00);
    check("under_miso1", miso_words[1], 32'h00);
    check("under_pulses", under8_cnt - u0, 32'd2);
    check("under_drain", exp8_q.size(), 32'd0);

    // Abort after 5 bits, then a clean frame
    a0 = abort8_cnt;
    mosi_words[0] = 32'hFF;
    frame(8, 5, 1'b0, 1'b0, 1'b1);
    check("abort_pulses", abort8_cnt - a0, 32'd1);
    check("abort_rx_kept", {24'd0, rx_data8}, 32'hAA);
    exp8_q.push_back(8'h96);
    mosi_words[0] = 32'h96;
    frame(8, 8, 1'b0, 1'b0, 1'b1);
    check("post_abort_drain", exp8_q.size(), 32'd0);
    check("post_abort_rx", {24'd0, rx_data8}, 32'h96);

    // Reset mid-frame after 3 bits
    mosi_words[0] = 32'hFF;
    frame(8, 3, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    ss8 = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    exp8_q.push_back(8'h5A);
    mosi_words[0] = 32'h5A;
    frame(8, 8, 1'b0, 1'b0, 1'b1);
    check("midrst_miso", miso_words[0], 32'h00);
    check("midrst_drain", exp8_q.size(), 32'd0);

    // sck activity with both selects high must be ignored
    for (int i = 0; i < 16; i++) begin
      s_sck = ~s_sck;
      repeat (4) @(negedge clk);
      if (i == 7) check("idle_oe8_mid", {31'd0, oe8}, 32'd0);
    end
    s_sck = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_oe8", {31'd0, oe8}, 32'd0);
    check("idle_oe16", {31'd0, oe16}, 32'd0);
    check("idle_miso8", {31'd0, miso8}, 32'd1);
    check("idle_busy8", {31'd0, busy8}, 32'd0);

    // 16-bit words with randomized sck phases
    push_tx(1'b1, 16'hBEEF);
    exp16_q.push_back(16'hC3A5); exp16_q.push_back(16'h5A0F);
    mosi_words[0] = 32'hC3A5; mosi_words[1] = 32'h5A0F;
    fork
      frame(16, 32, 1'b1, 1'b1, 1'b1);
      push_tx(1'b1, 16'h1234);
    join
    check("jit_miso0", miso_words[0], 32'hBEEF);
    check("jit_miso1", miso_words[1], 32'h1234);
    check("jit_drain", exp16_q.size(), 32'd0);
    check("jit_oe16_after", {31'd0, oe16}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
